// File: rtl/store_buffer_mc.sv
// Multi-channel store buffer: program-order circular queue with parallel write-back,
// in-order commit/drain and load bypass. Define SB_WB_FWD_EN to forward same-cycle write-backs.
module store_buffer_mc #(
    parameter int WORD_SIZE_P = 16,
    parameter int SB_ENTRY    = 8,
    parameter int NUM_WB      = 2,
    localparam int SBN_W      = $clog2(SB_ENTRY)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          alloc_v_i,
    output logic                          alloc_ready_o,
    output logic [SBN_W-1:0]              alloc_num_o,
    input  logic [NUM_WB-1:0]             wb_v_i,
    input  logic [NUM_WB*SBN_W-1:0]       wb_num_i,
    input  logic [NUM_WB*WORD_SIZE_P-1:0] wb_addr_i,
    input  logic [NUM_WB*WORD_SIZE_P-1:0] wb_data_i,
    input  logic                          commit_v_i,
    input  logic                          flush_i,
    input  logic [WORD_SIZE_P-1:0]        ld_addr_i,
    input  logic [SBN_W-1:0]              ld_sb_num_i,
    output logic                          ld_bypass_v_o,
    output logic [WORD_SIZE_P-1:0]        ld_bypass_data_o,
    output logic [SB_ENTRY-1:0]           sb_wb_vector_o,
    output logic [SBN_W-1:0]              sb_commit_pt_o,
    output logic                          data_mem_w_v_o,
    output logic [WORD_SIZE_P-1:0]        data_mem_w_addr_o,
    output logic [WORD_SIZE_P-1:0]        data_mem_w_data_o,
    output logic                          clear_v_o,
    output logic [SBN_W-1:0]              clear_num_o
);

    logic [SBN_W-1:0]       r_head, r_cpt, r_tail;
    logic [SBN_W:0]         r_count;
    logic [SB_ENTRY-1:0]    r_valid, r_wb, r_cmt;
    logic [WORD_SIZE_P-1:0] r_addr [SB_ENTRY];
    logic [WORD_SIZE_P-1:0] r_data [SB_ENTRY];

    logic [SBN_W-1:0]       w_wb_num  [NUM_WB];
    logic [WORD_SIZE_P-1:0] w_wb_addr [NUM_WB];
    logic [WORD_SIZE_P-1:0] w_wb_data [NUM_WB];

    logic                   w_alloc, w_drain;
    logic [SBN_W-1:0]       w_head_n, w_cpt_n, w_cdiff;
    logic [SBN_W:0]         w_count_n;
    logic [SB_ENTRY-1:0]    w_valid_n, w_wb_n, w_cmt_n;

    always_comb begin
        for (int unsigned k = 0; k < NUM_WB; k++) begin
            w_wb_num[k]  = wb_num_i[k*SBN_W +: SBN_W];
            w_wb_addr[k] = wb_addr_i[k*WORD_SIZE_P +: WORD_SIZE_P];
            w_wb_data[k] = wb_data_i[k*WORD_SIZE_P +: WORD_SIZE_P];
        end
    end

    assign alloc_ready_o = (r_count != (SBN_W+1)'(SB_ENTRY));
    assign w_alloc       = alloc_v_i & alloc_ready_o & ~flush_i;
    assign w_drain       = r_valid[r_head] & r_cmt[r_head];
    assign w_head_n      = r_head + SBN_W'(w_drain);
    assign w_cpt_n       = r_cpt + SBN_W'(commit_v_i);
    assign w_cdiff       = w_cpt_n - w_head_n;

    always_comb begin
        w_valid_n = r_valid;
        w_wb_n    = r_wb;
        w_cmt_n   = r_cmt;
        if (w_alloc) begin
            w_valid_n[r_tail] = 1'b1;
            w_wb_n[r_tail]    = 1'b0;
            w_cmt_n[r_tail]   = 1'b0;
        end
        for (int unsigned k = 0; k < NUM_WB; k++)
            if (wb_v_i[k] && r_valid[w_wb_num[k]])
                w_wb_n[w_wb_num[k]] = 1'b1;
        if (commit_v_i)
            w_cmt_n[r_cpt] = 1'b1;
        if (w_drain) begin
            w_valid_n[r_head] = 1'b0;
            w_cmt_n[r_head]   = 1'b0;
        end
        if (flush_i)
            w_valid_n = w_valid_n & w_cmt_n;
    end

    // On flush only committed entries remain; cpt==head is ambiguous between 0 and a
    // completely committed queue, resolved by looking at the surviving head entry.
    always_comb begin
        w_count_n = r_count + (SBN_W+1)'(w_alloc) - (SBN_W+1)'(w_drain);
        if (flush_i) begin
            if (w_cdiff == '0 && w_valid_n[w_head_n] && w_cmt_n[w_head_n])
                w_count_n = (SBN_W+1)'(SB_ENTRY);
            else
                w_count_n = {1'b0, w_cdiff};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_head  <= '0;
            r_cpt   <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_wb    <= '0;
            r_cmt   <= '0;
        end else begin
            r_head  <= w_head_n;
            r_cpt   <= w_cpt_n;
            r_tail  <= flush_i ? w_cpt_n : r_tail + SBN_W'(w_alloc);
            r_count <= w_count_n;
            r_valid <= w_valid_n;
            r_wb    <= w_wb_n;
            r_cmt   <= w_cmt_n;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < NUM_WB; k++) begin
            if (wb_v_i[k] && r_valid[w_wb_num[k]]) begin
                r_addr[w_wb_num[k]] <= w_wb_addr[k];
                r_data[w_wb_num[k]] <= w_wb_data[k];
            end
        end
    end

    // Scan oldest to youngest so the last hit is the youngest older store.
    always_comb begin
        logic [SBN_W-1:0]       range_len;
        logic [SBN_W-1:0]       idx;
        logic                   e_wb;
        logic [WORD_SIZE_P-1:0] e_addr;
        logic [WORD_SIZE_P-1:0] e_data;
        ld_bypass_v_o    = 1'b0;
        ld_bypass_data_o = '0;
        range_len        = ld_sb_num_i - r_head;
        for (int unsigned i = 0; i < SB_ENTRY; i++) begin
            idx    = r_head + SBN_W'(i);
            e_wb   = r_valid[idx] & r_wb[idx];
            e_addr = r_addr[idx];
            e_data = r_data[idx];
`ifdef SB_WB_FWD_EN
            for (int unsigned k = 0; k < NUM_WB; k++) begin
                if (wb_v_i[k] && r_valid[idx] && w_wb_num[k] == idx) begin
                    e_wb   = 1'b1;
                    e_addr = w_wb_addr[k];
                    e_data = w_wb_data[k];
                end
            end
`else
`endif
            if (SBN_W'(i) < range_len && e_wb && e_addr == ld_addr_i) begin
                ld_bypass_v_o    = 1'b1;
                ld_bypass_data_o = e_data;
            end
        end
    end

    assign alloc_num_o       = r_tail;
    assign sb_wb_vector_o    = r_valid & r_wb;
    assign sb_commit_pt_o    = r_cpt;
    assign data_mem_w_v_o    = w_drain;
    assign data_mem_w_addr_o = w_drain ? r_addr[r_head] : '0;
    assign data_mem_w_data_o = w_drain ? r_data[r_head] : '0;
    assign clear_v_o         = w_drain;
    assign clear_num_o       = w_drain ? r_head : '0;

    a_alloc_full: assert property (@(posedge clk_i) disable iff (reset_i)
        alloc_v_i |-> alloc_ready_o);
    a_commit_wb: assert property (@(posedge clk_i) disable iff (reset_i)
        commit_v_i |-> (r_valid[r_cpt] && r_wb[r_cpt]));

    for (genvar k = 0; k < NUM_WB; k++) begin : g_wb_chk
        a_wb_valid: assert property (@(posedge clk_i) disable iff (reset_i)
            wb_v_i[k] |-> r_valid[w_wb_num[k]]);
        for (genvar j = k + 1; j < NUM_WB; j++) begin : g_pair
            a_wb_distinct: assert property (@(posedge clk_i) disable iff (reset_i)
                (wb_v_i[k] && wb_v_i[j]) |-> (w_wb_num[k] != w_wb_num[j]));
        end
    end

endmodule
